// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream SRAM loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    HDR_RELEASE,
    BYTE_WAIT,
    BYTE_RELEASE,
    WRITE,
    DONE
  } loader_state_t;

  localparam logic [7:0] LF_CHAR = 8'h0A;

endpackage

// File: rtl/byte_word_packer.sv
// Steers successive bytes into the lanes of one SRAM word and flags a full word.
module byte_word_packer #(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned BIG_ENDIAN     = 1
) (
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic                        Restart,
  input  logic                        Load,
  input  logic [7:0]                  Byte_data,
  output logic [8*BYTES_PER_WORD-1:0] Word,
  output logic                        Full_c
);

  localparam int unsigned K_W = $clog2(BYTES_PER_WORD + 1);

  logic [K_W-1:0] k;
  logic [K_W-1:0] lane_c;

  // Big-endian fills from the top lane downwards.
  assign lane_c = (BIG_ENDIAN != 0) ? (K_W'(BYTES_PER_WORD - 1) - k) : k;
  assign Full_c = (k == K_W'(BYTES_PER_WORD));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      k    <= '0;
      Word <= '0;
    end else if (Restart) begin
      k <= '0;
    end else if (Load) begin
      for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
        if (lane_c == K_W'(i)) Word[8*i +: 8] <= Byte_data;
      end
      k <= k + K_W'(1);
    end
  end

endmodule

// File: rtl/byte_stream_sram_loader.sv
// Receive-byte stream to SRAM word writer with runtime start address and count.
// Optional header stripping is compiled in with HEADER_STRIP_EN.
module byte_stream_sram_loader
  import loader_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned HEADER_LINES   = 3,
  parameter int unsigned BIG_ENDIAN     = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Initialize,
  input  logic                        Enable,
  input  logic [ADDR_W-1:0]           Start_address,
  input  logic [ADDR_W:0]             Word_count,
  input  logic                        Byte_valid,
  input  logic [7:0]                  Byte_data,
  output logic                        Byte_unload,
  output logic                        Rx_enable,
  output logic [ADDR_W-1:0]           SRAM_address,
  output logic [8*BYTES_PER_WORD-1:0] SRAM_write_data,
  output logic                        SRAM_we_n,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Overflow,
  output logic [ADDR_W:0]             Words_written
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 4 || HEADER_LINES < 1 || HEADER_LINES > 15)
  begin : g_bad_params
    $error("byte_stream_sram_loader: parameter out of range");
  end

  loader_state_t    state_q, state_d;
  logic             unload_d, rx_en_d, we_n_d, busy_d, done_d, ovf_d;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d, words_d;
  logic             pk_clear_c, pk_restart_c, pk_load_c, word_full_c;
`ifdef HEADER_STRIP_EN
  logic [3:0]       lines_q, lines_d;
`endif

  assign pk_clear_c = Reset || Initialize;

  byte_word_packer #(
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .BIG_ENDIAN    (BIG_ENDIAN)
  ) u_packer (
    .Clock    (Clock),
    .Clear    (pk_clear_c),
    .Restart  (pk_restart_c),
    .Load     (pk_load_c),
    .Byte_data(Byte_data),
    .Word     (SRAM_write_data),
    .Full_c   (word_full_c)
  );

  always_ff @(posedge Clock) begin
    if (Reset || Initialize) begin
      state_q       <= IDLE;
      Byte_unload   <= 1'b0;
      Rx_enable     <= 1'b0;
      SRAM_address  <= '0;
      SRAM_we_n     <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Overflow      <= 1'b0;
      Words_written <= '0;
      remaining_q   <= '0;
`ifdef HEADER_STRIP_EN
      lines_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      Byte_unload   <= unload_d;
      Rx_enable     <= rx_en_d;
      SRAM_address  <= addr_d;
      SRAM_we_n     <= we_n_d;
      Busy          <= busy_d;
      Done          <= done_d;
      Overflow      <= ovf_d;
      Words_written <= words_d;
      remaining_q   <= remaining_d;
`ifdef HEADER_STRIP_EN
      lines_q       <= lines_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    unload_d     = Byte_unload;
    rx_en_d      = Rx_enable;
    we_n_d       = 1'b1;
    addr_d       = SRAM_address;
    done_d       = Done;
    ovf_d        = Overflow;
    words_d      = Words_written;
    remaining_d  = remaining_q;
    pk_restart_c = 1'b0;
    pk_load_c    = 1'b0;
`ifdef HEADER_STRIP_EN
    lines_d      = lines_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (Enable) begin
          addr_d      = Start_address;
          remaining_d = Word_count;
          done_d      = 1'b0;
          ovf_d       = 1'b0;
          words_d     = '0;
          rx_en_d     = 1'b1;
`ifdef HEADER_STRIP_EN
          lines_d     = '0;
`endif
          if (Word_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            rx_en_d = 1'b0;
          end else begin
`ifdef HEADER_STRIP_EN
            state_d = HDR_WAIT;
`else
            state_d = BYTE_WAIT;
`endif
          end
        end
      end
`ifdef HEADER_STRIP_EN
      HDR_WAIT: begin
        if (Byte_valid) begin
          unload_d = 1'b1;
          if (Byte_data == LF_CHAR) lines_d = lines_q + 4'd1;
          state_d = HDR_RELEASE;
        end
      end
      HDR_RELEASE: begin
        if (!Byte_valid) begin
          unload_d = 1'b0;
          state_d  = (lines_q == 4'(HEADER_LINES)) ? BYTE_WAIT : HDR_WAIT;
        end
      end
`endif
      BYTE_WAIT: begin
        if (Byte_valid) begin
          unload_d  = 1'b1;
          pk_load_c = 1'b1;
          state_d   = BYTE_RELEASE;
        end
      end
      BYTE_RELEASE: begin
        if (!Byte_valid) begin
          unload_d = 1'b0;
          if (word_full_c) begin
            state_d = WRITE;
            we_n_d  = 1'b0;
          end else begin
            state_d = BYTE_WAIT;
          end
        end
      end
      WRITE: begin
        pk_restart_c = 1'b1;
        words_d      = Words_written + CNT_W'(1);
        remaining_d  = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          rx_en_d = 1'b0;
        end else if (&SRAM_address) begin
          // Saturate at the top of the address space rather than wrap.
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = 1'b1;
          rx_en_d = 1'b0;
        end else begin
          addr_d  = SRAM_address + ADDR_W'(1);
          state_d = BYTE_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

endmodule

// File: tb/tb_byte_stream_sram_loader.sv
// Directed, table-driven bench for byte_stream_sram_loader (16-bit BE and 32-bit LE builds).
module tb_byte_stream_sram_loader;

  typedef struct {
    logic [17:0]       start;
    logic [18:0]       count;
    int                nbytes;
    logic [7:0][7:0]   bytes;
    int                nwr;
    logic [3:0][17:0]  waddr;
    logic [3:0][15:0]  wdata;
    logic              ovf;
    logic [17:0]       final_addr;
  } vec_t;

`ifdef HEADER_STRIP_EN
  localparam int HDR_LEN = 11;
`else
  localparam int HDR_LEN = 0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  hdr [11];

  logic        Initialize_a, Enable_a, Valid_a, Unload_a, Rx_a, We_a, Busy_a, Done_a, Ovf_a;
  logic [17:0] Start_a, Addr_a;
  logic [18:0] Count_a, Words_a;
  logic [7:0]  Data_a;
  logic [15:0] Wdata_a;

  logic        Initialize_b, Enable_b, Valid_b, Unload_b, Rx_b, We_b, Busy_b, Done_b, Ovf_b;
  logic [17:0] Start_b, Addr_b;
  logic [18:0] Count_b, Words_b;
  logic [7:0]  Data_b;
  logic [31:0] Wdata_b;

  logic [17:0] wr_addr_a [$];
  logic [15:0] wr_data_a [$];
  logic [17:0] wr_addr_b [$];
  logic [31:0] wr_data_b [$];
  logic        prev_we_a = 1'b1, prev_we_b = 1'b1;
  logic [17:0] prev_addr_a, prev_addr_b;
  logic [15:0] prev_data_a;
  logic [31:0] prev_data_b;

  always #5 Clock = ~Clock;

  byte_stream_sram_loader #(.BYTES_PER_WORD(2), .ADDR_W(18), .HEADER_LINES(3), .BIG_ENDIAN(1)) dut_a (
    .Clock(Clock), .Reset(Reset), .Initialize(Initialize_a), .Enable(Enable_a),
    .Start_address(Start_a), .Word_count(Count_a), .Byte_valid(Valid_a), .Byte_data(Data_a),
    .Byte_unload(Unload_a), .Rx_enable(Rx_a), .SRAM_address(Addr_a), .SRAM_write_data(Wdata_a),
    .SRAM_we_n(We_a), .Busy(Busy_a), .Done(Done_a), .Overflow(Ovf_a), .Words_written(Words_a)
  );

  byte_stream_sram_loader #(.BYTES_PER_WORD(4), .ADDR_W(18), .HEADER_LINES(3), .BIG_ENDIAN(0)) dut_b (
    .Clock(Clock), .Reset(Reset), .Initialize(Initialize_b), .Enable(Enable_b),
    .Start_address(Start_b), .Word_count(Count_b), .Byte_valid(Valid_b), .Byte_data(Data_b),
    .Byte_unload(Unload_b), .Rx_enable(Rx_b), .SRAM_address(Addr_b), .SRAM_write_data(Wdata_b),
    .SRAM_we_n(We_b), .Busy(Busy_b), .Done(Done_b), .Overflow(Ovf_b), .Words_written(Words_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitors: capture every strobe, check one-cycle pulse and stable address/data.
  always @(negedge Clock) begin
    if (We_a === 1'b0) begin
      wr_addr_a.push_back(Addr_a);
      wr_data_a.push_back(Wdata_a);
      chk("we_pulse_a", 64'(prev_we_a), 64'd1);
      chk("addr_stable_a", 64'(Addr_a), 64'(prev_addr_a));
      chk("data_stable_a", 64'(Wdata_a), 64'(prev_data_a));
    end
    prev_we_a   = We_a;
    prev_addr_a = Addr_a;
    prev_data_a = Wdata_a;
  end

  always @(negedge Clock) begin
    if (We_b === 1'b0) begin
      wr_addr_b.push_back(Addr_b);
      wr_data_b.push_back(Wdata_b);
      chk("we_pulse_b", 64'(prev_we_b), 64'd1);
      chk("data_stable_b", 64'(Wdata_b), 64'(prev_data_b));
    end
    if (prev_we_b === 1'b0) chk("done_after_we_b", 64'(Done_b), 64'd1);
    prev_we_b   = We_b;
    prev_addr_b = Addr_b;
    prev_data_b = Wdata_b;
  end

  task automatic start(input bit sel, input logic [17:0] addr, input logic [18:0] cnt);
    @(negedge Clock);
    if (sel) begin Start_b = addr; Count_b = cnt; Enable_b = 1'b1; end
    else     begin Start_a = addr; Count_a = cnt; Enable_a = 1'b1; end
    @(negedge Clock);
    Enable_a = 1'b0;
    Enable_b = 1'b0;
  endtask

  // Receiver model: hold valid until unload is seen, then drop and wait for release.
  task automatic feed(input bit sel, input logic [7:0] b);
    bit ok;
    @(negedge Clock);
    if (sel) begin Valid_b = 1'b1; Data_b = b; end
    else     begin Valid_a = 1'b1; Data_a = b; end
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge Clock);
      ok = sel ? Unload_b : Unload_a;
    end
    chk("unload_rise", 64'(ok), 64'd1);
    Valid_a = 1'b0;
    Valid_b = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge Clock);
      ok = sel ? !Unload_b : !Unload_a;
    end
    chk("unload_fall", 64'(ok), 64'd1);
  endtask

  task automatic send_header(input bit sel);
    for (int h = 0; h < HDR_LEN; h++) feed(sel, hdr[h]);
  endtask

  task automatic wait_done(input bit sel);
    bit d;
    d = 1'b0;
    for (int t = 0; t < 60 && !d; t++) begin
      @(negedge Clock);
      d = sel ? Done_b : Done_a;
    end
    chk("done_wait", 64'(d), 64'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_unload"}, 64'(Unload_a), 64'd0);
    chk({tag, "_rx"},     64'(Rx_a),     64'd0);
    chk({tag, "_addr"},   64'(Addr_a),   64'd0);
    chk({tag, "_wdata"},  64'(Wdata_a),  64'd0);
    chk({tag, "_we_n"},   64'(We_a),     64'd1);
    chk({tag, "_busy"},   64'(Busy_a),   64'd0);
    chk({tag, "_done"},   64'(Done_a),   64'd0);
    chk({tag, "_ovf"},    64'(Ovf_a),    64'd0);
    chk({tag, "_words"},  64'(Words_a),  64'd0);
  endtask

  task automatic idle_byte_ignored(input string tag);
    @(negedge Clock);
    Valid_a = 1'b1;
    Data_a  = 8'h55;
    repeat (5) @(negedge Clock);
    chk({tag, "_no_unload"}, 64'(Unload_a), 64'd0);
    Valid_a = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]} = {8'h50, 8'h36, 8'h0A, 8'h34, 8'h20, 8'h34};
    {hdr[6], hdr[7], hdr[8], hdr[9], hdr[10]}        = {8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};

    vecs[0] = '{start: 18'h00010, count: 19'd2, nbytes: 4, bytes: {32'h0, 32'h78563412},
                nwr: 2, waddr: {36'h0, 18'h00011, 18'h00010}, wdata: {32'h0, 16'h5678, 16'h1234},
                ovf: 1'b0, final_addr: 18'h00011};
    vecs[1] = '{start: 18'h3FFFF, count: 19'd5, nbytes: 2, bytes: {48'h0, 16'hCDAB},
                nwr: 1, waddr: {54'h0, 18'h3FFFF}, wdata: {48'h0, 16'hABCD},
                ovf: 1'b1, final_addr: 18'h3FFFF};
    vecs[2] = '{start: 18'h00020, count: 19'd1, nbytes: 2, bytes: {48'h0, 16'h0D0A},
                nwr: 1, waddr: {54'h0, 18'h00020}, wdata: {48'h0, 16'h0A0D},
                ovf: 1'b0, final_addr: 18'h00020};
    vecs[3] = '{start: 18'h00100, count: 19'd3, nbytes: 6, bytes: {16'h0, 48'h7FFE0180FF00},
                nwr: 3, waddr: {18'h0, 18'h00102, 18'h00101, 18'h00100},
                wdata: {16'h0, 16'hFE7F, 16'h8001, 16'h00FF},
                ovf: 1'b0, final_addr: 18'h00102};

    Reset = 1'b1;
    {Initialize_a, Enable_a, Valid_a, Initialize_b, Enable_b, Valid_b} = '0;
    {Start_a, Start_b, Count_a, Count_b, Data_a, Data_b} = '0;
    repeat (3) @(negedge Clock);
    chk_reset_a("reset");
    chk("reset_we_n_b", 64'(We_b), 64'd1);
    Reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wr_addr_a.delete();
      wr_data_a.delete();
      start(1'b0, vecs[i].start, vecs[i].count);
      chk($sformatf("v%0d_busy", i), 64'(Busy_a), 64'd1);
      chk($sformatf("v%0d_rx_on", i), 64'(Rx_a), 64'd1);
      send_header(1'b0);
      for (int j = 0; j < vecs[i].nbytes; j++) feed(1'b0, vecs[i].bytes[j]);
      wait_done(1'b0);
      chk($sformatf("v%0d_nwr", i), 64'(wr_addr_a.size()), 64'(vecs[i].nwr));
      for (int w = 0; w < vecs[i].nwr; w++) begin
        chk($sformatf("v%0d_waddr%0d", i, w), 64'(wr_addr_a[w]), 64'(vecs[i].waddr[w]));
        chk($sformatf("v%0d_wdata%0d", i, w), 64'(wr_data_a[w]), 64'(vecs[i].wdata[w]));
      end
      chk($sformatf("v%0d_ovf", i), 64'(Ovf_a), 64'(vecs[i].ovf));
      chk($sformatf("v%0d_words", i), 64'(Words_a), 64'(vecs[i].nwr));
      chk($sformatf("v%0d_addr", i), 64'(Addr_a), 64'(vecs[i].final_addr));
      chk($sformatf("v%0d_busy_end", i), 64'(Busy_a), 64'd0);
      chk($sformatf("v%0d_rx_off", i), 64'(Rx_a), 64'd0);
      idle_byte_ignored($sformatf("v%0d_done", i));
    end

    // Zero word count completes immediately without consuming bytes.
    wr_addr_a.delete();
    wr_data_a.delete();
    start(1'b0, 18'h00077, 19'd0);
    chk("zero_done", 64'(Done_a), 64'd1);
    chk("zero_busy", 64'(Busy_a), 64'd0);
    chk("zero_rx", 64'(Rx_a), 64'd0);
    chk("zero_words", 64'(Words_a), 64'd0);
    idle_byte_ignored("zero");
    chk("zero_nwr", 64'(wr_addr_a.size()), 64'd0);

    // Initialize mid-word abandons the partial word, then a clean restart.
    wr_addr_a.delete();
    wr_data_a.delete();
    start(1'b0, 18'h00040, 19'd1);
    send_header(1'b0);
    feed(1'b0, 8'h12);
    Initialize_a = 1'b1;
    @(negedge Clock);
    Initialize_a = 1'b0;
    chk_reset_a("init");
    repeat (3) @(negedge Clock);
    chk("init_nwr", 64'(wr_addr_a.size()), 64'd0);
    start(1'b0, 18'h00041, 19'd1);
    send_header(1'b0);
    feed(1'b0, 8'h9A);
    feed(1'b0, 8'hBC);
    wait_done(1'b0);
    chk("restart_nwr", 64'(wr_addr_a.size()), 64'd1);
    chk("restart_addr", 64'(wr_addr_a[0]), 64'h41);
    chk("restart_data", 64'(wr_data_a[0]), 64'h9ABC);

    // Little-endian 32-bit build.
    start(1'b1, 18'h00005, 19'd1);
    send_header(1'b1);
    feed(1'b1, 8'h01);
    feed(1'b1, 8'h02);
    feed(1'b1, 8'h03);
    feed(1'b1, 8'h04);
    wait_done(1'b1);
    chk("le_nwr", 64'(wr_addr_b.size()), 64'd1);
    chk("le_addr", 64'(wr_addr_b[0]), 64'h5);
    chk("le_data", 64'(wr_data_b[0]), 64'h04030201);
    chk("le_words", 64'(Words_b), 64'd1);
    chk("le_ovf", 64'(Ovf_b), 64'd0);

    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_stream_sram_loader.md
# byte_stream_sram_loader

Parametrised successor of the UART-to-SRAM receive path. Consumes a byte stream from a UART receive controller, optionally strips a text header of newline-terminated lines, assembles `BYTES_PER_WORD` bytes into one word, and writes each word to SRAM. Writes start at a runtime start address and stop after a runtime word count or at the top of the address space. It sits between the UART receive controller and the SRAM arbiter in the top-level loader path.

## Interface
Parameters:
- `BYTES_PER_WORD`, 2: bytes per SRAM word, 1..4. `DATA_W = 8*BYTES_PER_WORD`.
- `ADDR_W`, 18: SRAM address width.
- `HEADER_LINES`, 3: number of 8'h0A bytes terminating the header, 1..15. Used only with `HEADER_STRIP_EN`.
- `BIG_ENDIAN`, 1: 1 = first received byte goes to the MSB; 0 = first byte goes to the LSB.

Ports:
- `Clock`  in  1  single clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Initialize`  in  1  synchronous soft clear; same effect as `Reset`.
- `Enable`  in  1  start pulse; sampled in IDLE and DONE only.
- `Start_address`  in  `ADDR_W`  first write address, sampled on `Enable`.
- `Word_count`  in  `ADDR_W+1`  words to write, sampled on `Enable`.
- `Byte_valid`  in  1  byte available (receiver not empty).
- `Byte_data`  in  8  received byte.
- `Byte_unload`  out  1  unload request to the receiver.
- `Rx_enable`  out  1  receiver enable.
- `SRAM_address`  out  `ADDR_W`  write address.
- `SRAM_write_data`  out  `DATA_W`  assembled word.
- `SRAM_we_n`  out  1  active-low write strobe.
- `Busy`  out  1  high outside IDLE and DONE.
- `Done`  out  1  sticky completion flag.
- `Overflow`  out  1  sticky; set when the address limit is reached before the count completes.
- `Words_written`  out  `ADDR_W+1`  running count of completed writes.

## Operation
- Reset values: `Byte_unload`=0, `Rx_enable`=0, `SRAM_address`=0, `SRAM_write_data`=0, `SRAM_we_n`=1, `Busy`=0, `Done`=0, `Overflow`=0, `Words_written`=0, state = IDLE.
- Priority: `Reset` > `Initialize` > FSM.
- IDLE or DONE, on `Enable`=1:
  - latch `Start_address` into `SRAM_address` and `Word_count` into the remaining counter;
  - clear `Done`, `Overflow` and `Words_written`; set `Rx_enable`=1.
  - If `Word_count`=0: go to DONE with `Done`=1 and `Rx_enable`=0.
  - Otherwise go to HDR_WAIT (with header stripping) or BYTE_WAIT (without).
- HDR_WAIT: when `Byte_valid`=1, set `Byte_unload`=1. If `Byte_data`=8'h0A, increment the line counter. Go to HDR_RELEASE.
- HDR_RELEASE: when `Byte_valid`=0, clear `Byte_unload`. Go to BYTE_WAIT if the line counter equals `HEADER_LINES`, else return to HDR_WAIT.
- BYTE_WAIT: when `Byte_valid`=1:
  - set `Byte_unload`=1;
  - write `Byte_data` into byte lane `k` (lane `BYTES_PER_WORD-1-k` when `BIG_ENDIAN`=1) and increment `k`;
  - go to BYTE_RELEASE.
- BYTE_RELEASE: when `Byte_valid`=0, clear `Byte_unload`. Go to WRITE if `k`=`BYTES_PER_WORD`, else BYTE_WAIT.
- WRITE: `SRAM_we_n`=0 for exactly one cycle. Then:
  - `k` returns to 0 and `Words_written` increments;
  - if the remaining count reaches 0: go to DONE, `Done`=1, `Rx_enable`=0, address held;
  - else if `SRAM_address` = all-ones: go to DONE, `Done`=1, `Overflow`=1, address saturates (no wrap);
  - else increment the address and go to BYTE_WAIT.
- Bytes arriving in IDLE or DONE are not unloaded.
- Mid-operation `Initialize` or `Reset` abandons a partial word; nothing is written.

## Timing
- `Byte_unload` is registered: it rises one cycle after `Byte_valid` is sampled high, and falls one cycle after `Byte_valid` is sampled low.
- `SRAM_address` and `SRAM_write_data` are stable throughout the cycle in which `SRAM_we_n`=0, and during the cycle before it.
- Minimum latency from sampling the last byte of a word to the `SRAM_we_n` low cycle is 2 cycles, with an immediate `Byte_valid` drop.
- `Done` rises on the cycle after the final `SRAM_we_n` low cycle.
- `Busy` is registered with the state.

## Configuration
- `HEADER_STRIP_EN` defined: the HDR_WAIT and HDR_RELEASE states and the 4-bit line counter are compiled in.
- `HEADER_STRIP_EN` undefined: those states and the counter are absent. `Enable` goes directly to BYTE_WAIT, and every byte, including 8'h0A, is data.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t` (IDLE, HDR_WAIT, HDR_RELEASE, BYTE_WAIT, BYTE_RELEASE, WRITE, DONE);
  - constant `LF_CHAR`=8'h0A.
- One natural sub-module, `byte_word_packer`. It holds the lane index `k` and the endianness steering, and flags when a word is complete. The FSM stays in the top module.

## Test plan
- `BYTES_PER_WORD`=2, `BIG_ENDIAN`=1, no header, `Start_address`=0x00010, `Word_count`=2, bytes 12,34,56,78 -> writes 0x1234@0x10 and 0x5678@0x11; `Done`=1, `Words_written`=2.
- `BIG_ENDIAN`=0, `BYTES_PER_WORD`=4, bytes 01,02,03,04 -> 0x04030201; `SRAM_we_n` low for exactly 1 cycle.
- `HEADER_STRIP_EN`, `HEADER_LINES`=3, stream "P6\n4 4\n255\n" followed by AA,BB -> first write 0xAABB@`Start_address`; no header byte is written.
- `Start_address`=0x3FFFF, `Word_count`=5 -> one write @0x3FFFF; `Done`=1, `Overflow`=1, address stays 0x3FFFF.
- `Word_count`=0 -> `Done` on the next cycle; no write; `Byte_unload` stays 0.
- `Initialize` after the first byte of a word -> no write; all outputs return to reset values; a following `Enable` restarts cleanly.
